// File: rtl/voice_mixer_stereo_if.sv
// Bundle for the stereo voice mixer: config writes, sequencer outputs,
// pipeline tail samples and the mixed stereo frame.
interface voice_mixer_stereo_if #(
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8,
  parameter int PAN_W    = 7,
  parameter int OUT_W    = 24
);
  logic                       i_cfg_we;
  logic [7:0]                 i_cfg_voice;
  logic [GAIN_W-1:0]          i_cfg_gain;
  logic [PAN_W-1:0]           i_cfg_pan;
  logic [7:0]                 o_voice_index;
  logic [3:0]                 o_pipeline_state;
  logic                       i_sample_valid;
  logic [7:0]                 i_sample_voice;
  logic signed [SAMPLE_W-1:0] i_sample;
  logic signed [OUT_W-1:0]    o_left;
  logic signed [OUT_W-1:0]    o_right;
  logic                       o_sample_valid;

  modport master (
    output i_cfg_we, i_cfg_voice, i_cfg_gain, i_cfg_pan,
    output i_sample_valid, i_sample_voice, i_sample,
    input  o_voice_index, o_pipeline_state,
    input  o_left, o_right, o_sample_valid
  );

  modport slave (
    input  i_cfg_we, i_cfg_voice, i_cfg_gain, i_cfg_pan,
    input  i_sample_valid, i_sample_voice, i_sample,
    output o_voice_index, o_pipeline_state,
    output o_left, o_right, o_sample_valid
  );
endinterface

// File: rtl/voice_mixer_stereo.sv
// Time-multiplexed voice sequencer plus gain/pan stereo mixer with
// per-channel saturation and one strobe per voice sweep.
module voice_mixer_stereo #(
  parameter int NUM_VOICES = 256,
  parameter int STAGES     = 3,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_W     = 8,
  parameter int PAN_W      = 7,
  parameter int OUT_W      = 24
) (
  input logic i_clk,
  input logic i_reset_n,
  voice_mixer_stereo_if.slave bus
);
  localparam int VW  = $clog2(NUM_VOICES);
  localparam int SW  = SAMPLE_W + GAIN_W;
  localparam int AW  = SW + 8;
  localparam int P1  = SW + 1;
  localparam int P2  = SW + PAN_W + 2;
  localparam int PW1 = PAN_W + 1;
  localparam logic [PAN_W-1:0] PAN_CTR = PAN_W'(1) << (PAN_W - 1);
  localparam logic [PAN_W:0]   PAN_ONE = PW1'(1) << PAN_W;
  localparam longint OMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam logic signed [AW-1:0] SAT_HI = AW'(OMAX);
  localparam logic signed [AW-1:0] SAT_LO = AW'(-OMAX - 1);
  localparam logic [7:0] LAST = 8'(NUM_VOICES - 1);
  localparam logic [8:0] NV9  = 9'(NUM_VOICES);

  logic [3:0] state_q, state_d;
  logic [7:0] vidx_q, vidx_d;

  always_comb begin
    state_d = state_q + 4'd1;
    vidx_d  = vidx_q;
    if (state_q == 4'(STAGES - 1)) begin
      state_d = '0;
      vidx_d  = (vidx_q == LAST) ? '0 : vidx_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= '0;
      vidx_q  <= '0;
    end else begin
      state_q <= state_d;
      vidx_q  <= vidx_d;
    end
  end

  assign bus.o_pipeline_state = state_q;
  assign bus.o_voice_index    = vidx_q;

  logic [GAIN_W-1:0] gain_q [NUM_VOICES];
  logic [PAN_W-1:0]  pan_q  [NUM_VOICES];
  logic              cfg_hit;
  logic [VW-1:0]     cfg_idx;

  assign cfg_hit = bus.i_cfg_we && ({1'b0, bus.i_cfg_voice} < NV9);
  assign cfg_idx = bus.i_cfg_voice[VW-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        gain_q[v] <= '0;
        pan_q[v]  <= PAN_CTR;
      end
    end else if (cfg_hit) begin
      gain_q[cfg_idx] <= bus.i_cfg_gain;
      pan_q[cfg_idx]  <= bus.i_cfg_pan;
    end
  end

  // S1: gain lookup sees the table before any same-cycle write lands
  logic              smp_hit, smp_last;
  logic [VW-1:0]     smp_idx;
  logic signed [P1-1:0] smp_x, gain_x, prod1, sh1;

  assign smp_hit  = bus.i_sample_valid &&
                    ({1'b0, bus.i_sample_voice} < NV9);
  assign smp_last = bus.i_sample_voice == LAST;
  assign smp_idx  = bus.i_sample_voice[VW-1:0];
  assign smp_x    = P1'(bus.i_sample);
  assign gain_x   = P1'({1'b0, gain_q[smp_idx]});
  assign prod1    = smp_x * gain_x;
  assign sh1      = prod1 >>> (GAIN_W - 1);

  logic                 s1_v_q, s1_last_q;
  logic signed [SW-1:0] s1_scl_q;
  logic [PAN_W-1:0]     s1_pan_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_scl_q  <= '0;
      s1_pan_q  <= '0;
    end else begin
      s1_v_q    <= smp_hit;
      s1_last_q <= smp_last;
      s1_scl_q  <= sh1[SW-1:0];
      s1_pan_q  <= pan_q[smp_idx];
    end
  end

  logic [PAN_W:0]       pan_l;
  logic signed [P2-1:0] scl_x, wl_x, wr_x, pl, pr, shl, shr;

  assign pan_l = PAN_ONE - {1'b0, s1_pan_q};
  assign scl_x = P2'(s1_scl_q);
  assign wl_x  = P2'(pan_l);
  assign wr_x  = P2'(s1_pan_q);
  assign pl    = scl_x * wl_x;
  assign pr    = scl_x * wr_x;
  assign shl   = pl >>> PAN_W;
  assign shr   = pr >>> PAN_W;

  logic                 s2_v_q, s2_last_q;
  logic signed [SW-1:0] s2_l_q, s2_r_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      s2_l_q    <= '0;
      s2_r_q    <= '0;
    end else begin
      s2_v_q    <= s1_v_q;
      s2_last_q <= s1_last_q;
      s2_l_q    <= shl[SW-1:0];
      s2_r_q    <= shr[SW-1:0];
    end
  end

  function automatic logic [OUT_W-1:0] sat(input logic signed [AW-1:0] x);
    if (x > SAT_HI) return SAT_HI[OUT_W-1:0];
    if (x < SAT_LO) return SAT_LO[OUT_W-1:0];
    return x[OUT_W-1:0];
  endfunction

  logic signed [AW-1:0]    acc_l_q, acc_r_q, sum_l, sum_r;
  logic signed [OUT_W-1:0] left_q, right_q;
  logic                    ovld_q;

  assign sum_l = acc_l_q + AW'(s2_l_q);
  assign sum_r = acc_r_q + AW'(s2_r_q);

  // S3: the closing voice is folded into the frame, accumulators restart
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      ovld_q  <= 1'b0;
    end else begin
      ovld_q <= 1'b0;
      if (s2_v_q) begin
        if (s2_last_q) begin
          left_q  <= sat(sum_l);
          right_q <= sat(sum_r);
          ovld_q  <= 1'b1;
          acc_l_q <= '0;
          acc_r_q <= '0;
        end else begin
          acc_l_q <= sum_l;
          acc_r_q <= sum_r;
        end
      end
    end
  end

  assign bus.o_left         = left_q;
  assign bus.o_right        = right_q;
  assign bus.o_sample_valid = ovld_q;
endmodule

// File: doc/voice_mixer_stereo.md
Name: voice_mixer_stereo

Overview:
Parametrised successor to the mono voice mixer. It sequences the time-multiplexed voice pipeline by generating the voice index and pipeline phase, and accepts one sample per voice per frame from the pipeline tail (DDS→wavetable→ADSR). Each sample is scaled by a per-voice gain and split by a per-voice pan into left and right channels. A saturated stereo frame is emitted once per voice sweep with a one-cycle valid strobe. It replaces the fixed 3-phase, 256-voice, mono, wrap-on-overflow mixer.

Parameters:
NUM_VOICES, 256, number of time-multiplexed voices (2..256)
STAGES, 3, clock cycles per voice slot (pipeline phases), 1..16
SAMPLE_W, 16, signed input sample width
GAIN_W, 8, unsigned per-voice gain width; unity = 2^(GAIN_W-1)
PAN_W, 7, unsigned per-voice pan width; 0 = full left
OUT_W, 24, signed output sample width per channel

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  synchronous reset, active-low
i_cfg_we  in  1  per-voice config write strobe (SPI domain, already synchronised)
i_cfg_voice  in  8  voice index to configure
i_cfg_gain  in  GAIN_W  gain value
i_cfg_pan  in  PAN_W  pan value
o_voice_index  out  8  current voice slot driven to the pipeline head
o_pipeline_state  out  4  current phase 0..STAGES-1
i_sample_valid  in  1  pipeline tail sample valid
i_sample_voice  in  8  voice index tagged on the tail sample
i_sample  in  SAMPLE_W  signed voice sample
o_left  out  OUT_W  signed mixed left sample
o_right  out  OUT_W  signed mixed right sample
o_sample_valid  out  1  one-cycle pulse: new stereo frame on o_left/o_right

Behaviour:
- Reset (i_reset_n low at an i_clk edge): o_voice_index=0, o_pipeline_state=0, o_left=0, o_right=0, o_sample_valid=0. Accumulators and in-flight pipeline stages are cleared. All gains=0 (muted), all pans=2^(PAN_W-1) (centre). Reset mid-frame discards the partial frame; no strobe.
- Sequencer: o_pipeline_state counts 0..STAGES-1 and wraps. o_voice_index increments on the cycle where state==STAGES-1, and wraps from NUM_VOICES-1 to 0.
- Config: on i_cfg_we with i_cfg_voice<NUM_VOICES, gain/pan for that voice update on the next edge. Writes with an index >= NUM_VOICES are ignored. A write and a sample for the same voice in the same cycle: the sample uses the old value.
- Datapath is 3 registered stages after the i_sample_valid cycle:
  - S1: scaled = (sample*gain)>>>(GAIN_W-1), kept at full width (SAMPLE_W+GAIN_W), signed arithmetic shift.
  - S2: l = (scaled*(2^PAN_W - pan))>>>PAN_W; r = (scaled*pan)>>>PAN_W.
  - S3: add into 2 accumulators of width SAMPLE_W+GAIN_W+8 (no internal overflow possible).
- Samples with i_sample_voice >= NUM_VOICES are dropped and do not enter S1.
- Frame close: when a sample with i_sample_voice==NUM_VOICES-1 reaches S3, o_left/o_right are loaded with saturate(acc + this contribution) and o_sample_valid pulses.
  - This happens exactly 3 cycles after that sample's valid cycle.
  - Accumulators restart from zero on the same edge; no sample is lost across the boundary.
- Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] independently per channel.
- Outputs hold between strobes.
- Back-to-back valid samples every cycle are supported (STAGES=1).

Test Plan:
1. Reset, then run 2 full sweeps with NUM_VOICES=4, STAGES=3 → o_voice_index sequence 0,0,0,1,1,1,2,2,2,3,3,3,0…; o_pipeline_state 0,1,2 repeating.
2. Run with no config writes, all samples=1000 → frames with o_left=o_right=0 (default gain 0 mutes).
3. NUM_VOICES=4; gain=128, pan=64 for all voices; every sample=1000 → o_left=o_right=2000; o_sample_valid 3 cycles after the voice-3 valid.
4. Voice0 pan=0, others gain=0, voice0 sample=-1000, gain=128 → o_left=-1000, o_right=0. Then set pan=127 → o_left=-8 (exact: -1000*1>>>7 = -8), o_right=-993.
5. OUT_W=16; all 4 voices sample=32767, gain=255, pan=0 → o_left=32767 (saturated), o_right=0. Repeat with -32768 → o_left=-32768.
6. Assert i_reset_n low for one cycle after voice 2 of a frame → no strobe for that frame; the next full frame is correct. Config write to voice 9 (≥NUM_VOICES) → no effect on any voice.
